// File: rtl/dispatch_ctrl_pkg.sv
// dispatch_ctrl_pkg: FU select encodings shared by decode and dispatch.
package dispatch_ctrl_pkg;
    typedef enum logic [1:0] {
        FU_SEL_RS     = 2'd0,
        FU_SEL_LOAD   = 2'd1,
        FU_SEL_BRANCH = 2'd2,
        FU_SEL_NONE   = 2'd3
    } fu_sel_e;
endpackage

// File: rtl/dispatch_ctrl_credit_cnt.sv
// credit_cnt: free-entry counter for one FU; a dispatch takes a credit, a return gives one back.
module credit_cnt #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic take_i,
    input  logic ret_i,
    output logic zero_o,
    output logic ovf_o
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        ovf_o  = ret_i && !take_i && (cnt_q == W'(MAX));
        zero_o = (cnt_q == '0);
        cnt_d  = (take_i && !ret_i) ? cnt_q - 1'b1 :
                 (ret_i && !take_i && !ovf_o) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= W'(MAX);
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: credit-gated dispatch of the decoded instruction plus round-robin
// thread selection that skips threads waiting on an unresolved branch.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int N_THREADS  = 4,
    parameter int RS_CREDITS = 8,
    parameter int LD_CREDITS = 4,
    parameter int BR_CREDITS = 2,
    localparam int TW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_THREADS-1:0] thr_req_i,
    output logic [N_THREADS-1:0] thr_grant_o,
    input  logic                 dec_valid_i,
    input  logic [1:0]           dec_fu_sel_i,
    input  logic [TW-1:0]        dec_thread_i,
    output logic                 stall_o,
    output logic                 rs_valid_o,
    output logic                 ld_valid_o,
    output logic                 br_valid_o,
    output logic                 none_valid_o,
    input  logic                 rs_ret_i,
    input  logic                 ld_ret_i,
    input  logic                 br_ret_i,
    input  logic                 br_res_i,
    input  logic [TW-1:0]        br_res_thread_i,
    output logic                 credit_err_o
);
    logic rs_zero, ld_zero, br_zero, rs_ovf, ld_ovf, br_ovf;
    logic sel_zero, disp, found;
    logic [N_THREADS-1:0] blk_q, blk_d, elig;
    logic [TW-1:0] ptr_q, ptr_d, gidx;
    logic err_q, err_d;
    int idx;

    credit_cnt #(.MAX(RS_CREDITS)) u_rs (.clk(clk), .rst(rst), .take_i(rs_valid_o), .ret_i(rs_ret_i), .zero_o(rs_zero), .ovf_o(rs_ovf));
    credit_cnt #(.MAX(LD_CREDITS)) u_ld (.clk(clk), .rst(rst), .take_i(ld_valid_o), .ret_i(ld_ret_i), .zero_o(ld_zero), .ovf_o(ld_ovf));
    credit_cnt #(.MAX(BR_CREDITS)) u_br (.clk(clk), .rst(rst), .take_i(br_valid_o), .ret_i(br_ret_i), .zero_o(br_zero), .ovf_o(br_ovf));

    // Stall looks only at registered credit, so a same-cycle return cannot unblock it.
    always_comb begin
        sel_zero     = (dec_fu_sel_i == FU_SEL_RS)     ? rs_zero :
                       (dec_fu_sel_i == FU_SEL_LOAD)   ? ld_zero :
                       (dec_fu_sel_i == FU_SEL_BRANCH) ? br_zero : 1'b0;
        stall_o      = !rst && dec_valid_i && sel_zero;
        disp         = !rst && dec_valid_i && !sel_zero;
        rs_valid_o   = disp && (dec_fu_sel_i == FU_SEL_RS);
        ld_valid_o   = disp && (dec_fu_sel_i == FU_SEL_LOAD);
        br_valid_o   = disp && (dec_fu_sel_i == FU_SEL_BRANCH);
        none_valid_o = disp && (dec_fu_sel_i == FU_SEL_NONE);
        err_d        = err_q | rs_ovf | ld_ovf | br_ovf;
        blk_d        = (blk_q & ~(br_res_i ? N_THREADS'(1) << br_res_thread_i : '0))
                     | (br_valid_o ? N_THREADS'(1) << dec_thread_i : '0);
    end

    always_comb begin
        elig  = thr_req_i & ~blk_q;
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        for (int i = 0; i < N_THREADS; i++) begin
            idx = (int'(ptr_q) + i) % N_THREADS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = TW'(idx);
            end
        end
        thr_grant_o = (!rst && !stall_o && found) ? N_THREADS'(1) << gidx : '0;
        ptr_d       = !(|thr_grant_o) ? ptr_q :
                      (gidx == TW'(N_THREADS - 1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_q <= '0;
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            blk_q <= blk_d;
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    assign credit_err_o = err_q;
endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed stimulus with a queued scoreboard checked at each falling edge.
module tb_dispatch_ctrl;
    import dispatch_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] thr_req_i = '0;
    logic [3:0] thr_grant_o;
    logic       dec_valid_i = 1'b0;
    logic [1:0] dec_fu_sel_i = FU_SEL_NONE;
    logic [1:0] dec_thread_i = '0;
    logic       stall_o, rs_valid_o, ld_valid_o, br_valid_o, none_valid_o, credit_err_o;
    logic       rs_ret_i = 1'b0, ld_ret_i = 1'b0, br_ret_i = 1'b0;
    logic       br_res_i = 1'b0;
    logic [1:0] br_res_thread_i = '0;

    dispatch_ctrl dut (
        .clk(clk), .rst(rst), .thr_req_i(thr_req_i), .thr_grant_o(thr_grant_o),
        .dec_valid_i(dec_valid_i), .dec_fu_sel_i(dec_fu_sel_i), .dec_thread_i(dec_thread_i),
        .stall_o(stall_o), .rs_valid_o(rs_valid_o), .ld_valid_o(ld_valid_o),
        .br_valid_o(br_valid_o), .none_valid_o(none_valid_o),
        .rs_ret_i(rs_ret_i), .ld_ret_i(ld_ret_i), .br_ret_i(br_ret_i),
        .br_res_i(br_res_i), .br_res_thread_i(br_res_thread_i), .credit_err_o(credit_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [9:0] v;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [9:0] act;

    localparam logic [3:0] S_0 = 4'b0000, S_RS = 4'b1000, S_LD = 4'b0100, S_BR = 4'b0010, S_NO = 4'b0001;

    assign act = {thr_grant_o, stall_o, rs_valid_o, ld_valid_o, br_valid_o, none_valid_o, credit_err_o};

    // Output order: grant[3:0] stall rs ld br none err
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b (grant,stall,rs,ld,br,none,err)", e.nm, act, e.v);
            end
        end
    end

    function automatic logic [9:0] ex(logic [3:0] g, logic s, logic [3:0] st, logic er);
        return {g, s, st, er};
    endfunction

    task automatic cyc(input string nm, input logic r, input logic [3:0] req, input logic dv,
                       input logic [1:0] fu, input logic [1:0] thr, input logic [2:0] ret,
                       input logic bres, input logic [1:0] bthr, input logic [9:0] ev);
        @(posedge clk);
        #1;
        rst = r;
        thr_req_i = req;
        dec_valid_i = dv;
        dec_fu_sel_i = fu;
        dec_thread_i = thr;
        {rs_ret_i, ld_ret_i, br_ret_i} = ret;
        br_res_i = bres;
        br_res_thread_i = bthr;
        q.push_back('{nm, ev});
    endtask

    initial begin
        cyc("rst_outs", 1, 4'hF, 1, FU_SEL_LOAD, 0, 3'b000, 0, 0, ex(S_0, 0, S_0, 0));
        for (int i = 0; i < 5; i++)
            cyc("rr_grant", 0, 4'hF, 0, FU_SEL_NONE, 0, 3'b000, 0, 0, ex(4'b0001 << (i % 4), 0, S_0, 0));
        for (int i = 0; i < 4; i++)
            cyc("ld_disp", 0, 4'h0, 1, FU_SEL_LOAD, 0, 3'b000, 0, 0, ex(S_0, 0, S_LD, 0));
        cyc("ld_stall5", 0, 4'hF, 1, FU_SEL_LOAD, 0, 3'b000, 0, 0, ex(S_0, 1, S_0, 0));
        cyc("ld_ret_nobypass", 0, 4'hF, 1, FU_SEL_LOAD, 0, 3'b010, 0, 0, ex(S_0, 1, S_0, 0));
        cyc("ld_after_ret", 0, 4'hF, 1, FU_SEL_LOAD, 0, 3'b000, 0, 0, ex(4'b0010, 0, S_LD, 0));
        cyc("ld_empty_again", 0, 4'h0, 1, FU_SEL_LOAD, 0, 3'b000, 0, 0, ex(S_0, 1, S_0, 0));
        for (int i = 0; i < 4; i++)
            cyc("ld_refill", 0, 4'h0, 0, FU_SEL_LOAD, 0, 3'b010, 0, 0, ex(S_0, 0, S_0, 0));
        cyc("ld_full_disp", 0, 4'h0, 1, FU_SEL_LOAD, 0, 3'b010, 0, 0, ex(S_0, 0, S_LD, 0));
        cyc("none_disp", 0, 4'h0, 1, FU_SEL_NONE, 0, 3'b000, 0, 0, ex(S_0, 0, S_NO, 0));
        cyc("br_disp_t2", 0, 4'h0, 1, FU_SEL_BRANCH, 2, 3'b000, 0, 0, ex(S_0, 0, S_BR, 0));
        cyc("skip_t2_a", 0, 4'hF, 0, FU_SEL_NONE, 0, 3'b000, 0, 0, ex(4'b1000, 0, S_0, 0));
        cyc("skip_t2_b", 0, 4'hF, 0, FU_SEL_NONE, 0, 3'b000, 0, 0, ex(4'b0001, 0, S_0, 0));
        cyc("skip_t2_c", 0, 4'hF, 0, FU_SEL_NONE, 0, 3'b000, 0, 0, ex(4'b0010, 0, S_0, 0));
        cyc("skip_t2_d", 0, 4'hF, 0, FU_SEL_NONE, 0, 3'b000, 0, 0, ex(4'b1000, 0, S_0, 0));
        cyc("res_t2", 0, 4'hF, 0, FU_SEL_NONE, 0, 3'b001, 1, 2, ex(4'b0001, 0, S_0, 0));
        cyc("regrant_a", 0, 4'hF, 0, FU_SEL_NONE, 0, 3'b000, 0, 0, ex(4'b0010, 0, S_0, 0));
        cyc("regrant_t2", 0, 4'hF, 0, FU_SEL_NONE, 0, 3'b000, 0, 0, ex(4'b0100, 0, S_0, 0));
        cyc("br_set_wins", 0, 4'h0, 1, FU_SEL_BRANCH, 1, 3'b000, 1, 1, ex(S_0, 0, S_BR, 0));
        cyc("t1_blocked", 0, 4'b0010, 0, FU_SEL_NONE, 0, 3'b001, 0, 0, ex(S_0, 0, S_0, 0));
        cyc("t1_res_cycle", 0, 4'b0010, 0, FU_SEL_NONE, 0, 3'b000, 1, 1, ex(S_0, 0, S_0, 0));
        cyc("t1_free", 0, 4'b0010, 0, FU_SEL_NONE, 0, 3'b000, 0, 0, ex(4'b0010, 0, S_0, 0));
        cyc("rs_with_grant", 0, 4'b0101, 1, FU_SEL_RS, 0, 3'b000, 0, 0, ex(4'b0100, 0, S_RS, 0));
        cyc("rs_ret_ok", 0, 4'h0, 0, FU_SEL_NONE, 0, 3'b100, 0, 0, ex(S_0, 0, S_0, 0));
        cyc("rs_ret_at_max", 0, 4'h0, 0, FU_SEL_NONE, 0, 3'b100, 0, 0, ex(S_0, 0, S_0, 0));
        cyc("err_sticky", 0, 4'h0, 0, FU_SEL_NONE, 0, 3'b000, 0, 0, ex(S_0, 0, S_0, 1));
        for (int i = 0; i < 8; i++)
            cyc("rs_cap8", 0, 4'h0, 1, FU_SEL_RS, 0, 3'b000, 0, 0, ex(S_0, 0, S_RS, 1));
        cyc("rs_stall9", 0, 4'hF, 1, FU_SEL_RS, 0, 3'b000, 0, 0, ex(S_0, 1, S_0, 1));
        cyc("rst_mid", 1, 4'hF, 1, FU_SEL_RS, 0, 3'b000, 0, 0, ex(S_0, 0, S_0, 0));
        cyc("rs_after_rst", 0, 4'h0, 1, FU_SEL_RS, 0, 3'b000, 0, 0, ex(S_0, 0, S_RS, 0));
        cyc("ptr_after_rst", 0, 4'hF, 0, FU_SEL_NONE, 0, 3'b000, 0, 0, ex(4'b0001, 0, S_0, 0));
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
